scanline_fetch_controller: RTL

Sequences the frame-buffer read path for the VGA pixel output stage. It owns the horizontal and vertical raster counters and the InFrame qualifier, and issues in-order read requests to the frame-buffer memory arbiter. Returned words are buffered in a prefetch FIFO and popped one per active pixel, so colors_data, InFrame and the counters reach the pixel generator cycle-aligned.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 49 ++++
 rtl/scanline_fetch_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 480p raster timing, pixel-word layout and fetch FSM states for the
// scanline fetch path.
package vga_timing_pkg;

  localparam int VGA_H_ACT  = 640;
  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_H_TOT  = VGA_H_ACT + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACT  = 480;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;
  localparam int VGA_V_TOT  = VGA_V_ACT + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_word_t;

  // Magenta marker shown when an active pixel finds no fetched data.
  localparam pixel_word_t UNDERFLOW_WORD = '{pad: 8'h00, b: 8'hFF, g: 8'h00, r: 8'hFF};

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DONE  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head word, synchronous clear and occupancy
// count. Pop on empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // The issuer's credit accounting must never let a push land on a full FIFO.
  always_ff @(posedge clock) begin
    if (!reset && !clear) assert (!(push && count == CW'(DEPTH)));
  end

endmodule

// File: rtl/scanline_fetch_controller.sv
// Raster counters plus in-order frame-buffer prefetch; pops one word per active
// pixel so colors_data, InFrame and the counters leave aligned.
module scanline_fetch_controller
  import vga_timing_pkg::*;
#(
  parameter int          H_ACT           = VGA_H_ACT,
  parameter int          H_FP            = VGA_H_FP,
  parameter int          H_SYNC          = VGA_H_SYNC,
  parameter int          H_BP            = VGA_H_BP,
  parameter int          V_ACT           = VGA_V_ACT,
  parameter int          V_FP            = VGA_V_FP,
  parameter int          V_SYNC          = VGA_V_SYNC,
  parameter int          V_BP            = VGA_V_BP,
  parameter int          FIFO_DEPTH      = 16,
  parameter int          ADDR_W          = 19,
  parameter logic [31:0] UNDERFLOW_COLOR = UNDERFLOW_WORD
) (
  input  logic              clock,
  input  logic              reset,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [31:0]       rd_data,
  output logic [31:0]       Horz_Count,
  output logic [31:0]       Vert_Count,
  output logic              InFrame,
  output logic [31:0]       colors_data,
  output logic              underflow
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int NPIX  = H_ACT * V_ACT;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state, state_nxt;
  logic [31:0]       h_nxt, v_nxt;
  logic              h_wrap, vblank_entry, in_nxt;
  logic              accept, push, fifo_clear, fifo_empty, req_nxt;
  logic [CW-1:0]     fifo_count, cnt_nxt, outstanding, out_nxt;
  logic [CW:0]       credit_sum;
  logic [ADDR_W-1:0] addr_nxt;
  pixel_word_t       fifo_head;

  // Next-state raster position; every registered output is derived from it.
  always_comb begin
    h_wrap       = (Horz_Count == 32'(H_TOT - 1));
    h_nxt        = h_wrap ? 32'd0 : Horz_Count + 32'd1;
    v_nxt        = Vert_Count;
    if (h_wrap) v_nxt = (Vert_Count == 32'(V_TOT - 1)) ? 32'd0 : Vert_Count + 32'd1;
    vblank_entry = h_wrap && (v_nxt == 32'(V_ACT));
    in_nxt       = (h_nxt < 32'(H_ACT)) && (v_nxt < 32'(V_ACT));
  end

  assign accept = rd_req && rd_ack;
  assign push   = rd_valid && (state != DRAIN);

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (fifo_clear),
    .push  (push),
    .pop   (in_nxt),
    .din   (rd_data),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt  = state;
    fifo_clear = 1'b0;
    addr_nxt   = accept ? rd_addr + ADDR_W'(1) : rd_addr;
    case (state)
      FETCH: if (accept && rd_addr == ADDR_W'(NPIX - 1)) state_nxt = DONE;
      DONE:  ;
      DRAIN: if (outstanding == '0) begin
        fifo_clear = 1'b1;
        addr_nxt   = '0;
        state_nxt  = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
    if (vblank_entry) state_nxt = DRAIN;

    out_nxt    = outstanding + CW'(accept) - CW'(rd_valid);
    cnt_nxt    = fifo_clear ? '0 : fifo_count + CW'(push) - CW'(in_nxt && !fifo_empty);
    // Held requests stay legal: without an accept the credit sum can only shrink.
    credit_sum = {1'b0, cnt_nxt} + {1'b0, out_nxt};
    req_nxt    = (state_nxt == FETCH) && (credit_sum < (CW + 1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      Horz_Count  <= 32'd0;
      Vert_Count  <= 32'(V_ACT);
      InFrame     <= 1'b0;
      colors_data <= 32'd0;
      underflow   <= 1'b0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      outstanding <= '0;
      state       <= FETCH;
    end else begin
      Horz_Count  <= h_nxt;
      Vert_Count  <= v_nxt;
      InFrame     <= in_nxt;
      colors_data <= !in_nxt ? 32'd0 : (fifo_empty ? UNDERFLOW_COLOR : fifo_head);
      if (in_nxt && fifo_empty) underflow <= 1'b1;
      rd_req      <= req_nxt;
      rd_addr     <= addr_nxt;
      outstanding <= out_nxt;
      state       <= state_nxt;
    end
  end

endmodule
